bcd2bin: RTL and testbench

- Pipelined converter from signed BCD to two's-complement binary; the return path paired with the binary-to-BCD converter.
- Input word: {sign, DIGITS packed BCD digits, MSD first}. Output: BIN_W-bit two's complement.
- Range errors and illegal digits are flagged. Fixed latency, one word per clock, no backpressure.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_mac_stage.sv | 26 ++
 rtl/bcd2bin.sv | 159 +++++++++++++++
 tb/tb_bcd2bin.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by both the BCD-to-binary and binary-to-BCD
// converters: digit geometry, word width helper and digit legality check.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_DIGIT_MAX = 9;

  // Width of a signed BCD word: one sign bit plus the packed digits.
  function automatic int unsigned bcd_word_w(input int unsigned digits);
    return BCD_DIGIT_W * digits + 1;
  endfunction

  // A BCD digit is illegal when it encodes a value above 9.
  function automatic logic bcd_digit_illegal(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_mac_stage.sv
// One Horner step of the BCD-to-binary conversion: acc_o_c = acc_i*10 + digit.
// Purely combinational; the top places pipeline registers between instances.
//
// Ports:
//   acc_i      ACC_W    accumulator from the previous stage
//   digit      4        BCD digit consumed by this stage
//   acc_o_c    ACC_W    updated accumulator (combinational)
//   illegal_c  1        digit is above 9 (combinational)
module bcd_mac_stage
  import bcd_pkg::*;
#(
  parameter int unsigned ACC_W = 14
) (
  input  logic [ACC_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [ACC_W-1:0]       acc_o_c,
  output logic                   illegal_c
);

  // Multiply by ten as x*8 + x*2 to keep the step adder-only.
  always_comb begin
    acc_o_c   = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit);
    illegal_c = bcd_digit_illegal(digit);
  end

endmodule

// File: rtl/bcd2bin.sv
// Pipelined signed-BCD to two's-complement converter. One word per clock,
// fixed latency of DIGITS+1 edges from bcd capture to registered result.
//
// Ports:
//   clk      1             clock, rising edge
//   rstn     1             asynchronous active-low reset
//   bcd      4*DIGITS+1    {sign, MSD .. LSD}; sign=1 means negative
//   bcd_vid  1             bcd valid this cycle
//   bin      BIN_W         two's-complement result, 0 when bin_vid=0
//   bin_vid  1             result valid
//   ovf      1             magnitude out of range (qualified by bin_vid)
//   err      1             some digit above 9 (qualified by bin_vid)
//
// Build option:
//   BCD2BIN_SAT_EN  when defined, overflowing results saturate to the
//                   nearest representable extreme; otherwise they wrap.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 11
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [bcd_word_w(DIGITS)-1:0]   bcd,
  input  logic                            bcd_vid,
  output logic [BIN_W-1:0]                bin,
  output logic                            bin_vid,
  output logic                            ovf,
  output logic                            err
);

  localparam int unsigned WORD_W   = bcd_word_w(DIGITS);
  localparam int unsigned DIG_BITS = BCD_DIGIT_W * DIGITS;
  localparam int unsigned ACC_W    = $clog2(10 ** DIGITS);
  // Comparison width wide enough for both the accumulator and the limits.
  localparam int unsigned CMP_W    = ((ACC_W > BIN_W) ? ACC_W : BIN_W) + 1;

  localparam logic [CMP_W-1:0] POS_LIM = CMP_W'((2 ** (BIN_W - 1)) - 1);
  localparam logic [CMP_W-1:0] NEG_LIM = CMP_W'(2 ** (BIN_W - 1));

  // Per-stage sideband: index 0 is the capture stage, DIGITS the last MAC.
  logic [DIGITS:0]       vid_q;
  logic [DIGITS:0]       sign_q;
  logic [DIGITS:0]       err_q;
  logic [DIG_BITS-1:0]   dig_q [DIGITS];
  logic [ACC_W-1:0]      acc_q [1:DIGITS];

  logic [ACC_W-1:0]      mac_acc_c [1:DIGITS];
  logic [DIGITS:1]       mac_ill_c;
  logic                  err_s0_c;

  // Illegal-digit detection on the incoming word.
  always_comb begin
    err_s0_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      err_s0_c = err_s0_c | bcd_digit_illegal(bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

  // Horner stages: stage k folds in digit index DIGITS-k (MSD first).
  for (genvar k = 1; k <= int'(DIGITS); k++) begin : g_stage
    logic [ACC_W-1:0] acc_in;

    if (k == 1) begin : g_first
      assign acc_in = '0;
    end else begin : g_next
      assign acc_in = acc_q[k-1];
    end

    bcd_mac_stage #(
      .ACC_W (ACC_W)
    ) u_mac (
      .acc_i     (acc_in),
      .digit     (dig_q[k-1][BCD_DIGIT_W*(int'(DIGITS)-k) +: BCD_DIGIT_W]),
      .acc_o_c   (mac_acc_c[k]),
      .illegal_c (mac_ill_c[k])
    );
  end

  // Pipeline registers: capture stage plus one register per MAC stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vid_q  <= '0;
      sign_q <= '0;
      err_q  <= '0;
      for (int k = 0; k < int'(DIGITS); k++) begin
        dig_q[k] <= '0;
      end
      for (int k = 1; k <= int'(DIGITS); k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      vid_q    <= {vid_q[DIGITS-1:0], bcd_vid};
      sign_q   <= {sign_q[DIGITS-1:0], bcd[WORD_W-1]};
      err_q[0] <= err_s0_c;
      dig_q[0] <= bcd[DIG_BITS-1:0];
      for (int k = 1; k < int'(DIGITS); k++) begin
        dig_q[k] <= dig_q[k-1];
      end
      for (int k = 1; k <= int'(DIGITS); k++) begin
        acc_q[k] <= mac_acc_c[k];
        err_q[k] <= err_q[k-1] | mac_ill_c[k];
      end
    end
  end

  logic [CMP_W-1:0]  acc_ext;
  logic [CMP_W-1:0]  mag_c;
  logic              ovf_c;
  logic [BIN_W-1:0]  bin_d;
  logic              vid_d;
  logic              ovf_d;
  logic              err_d;

  // Output stage: range check, sign application and invalid-slot zeroing.
  always_comb begin
    acc_ext = CMP_W'(acc_q[DIGITS]);
    mag_c   = sign_q[DIGITS] ? (~acc_ext + CMP_W'(1)) : acc_ext;
    ovf_c   = sign_q[DIGITS] ? (acc_ext > NEG_LIM) : (acc_ext > POS_LIM);

    bin_d = '0;
    vid_d = vid_q[DIGITS];
    ovf_d = 1'b0;
    err_d = 1'b0;

    if (vid_q[DIGITS]) begin
      if (err_q[DIGITS]) begin
        err_d = 1'b1;
      end else if (ovf_c) begin
        ovf_d = 1'b1;
`ifdef BCD2BIN_SAT_EN
        bin_d = sign_q[DIGITS] ? {1'b1, {(BIN_W-1){1'b0}}}
                               : {1'b0, {(BIN_W-1){1'b1}}};
`else
        bin_d = BIN_W'(mag_c);
`endif
      end else begin
        bin_d = BIN_W'(mag_c);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin     <= '0;
      bin_vid <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      bin     <= bin_d;
      bin_vid <= vid_d;
      ovf     <= ovf_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin (DIGITS=4, BIN_W=11). Expected results are
// computed from integer arithmetic when a word is driven, queued, and popped
// when bin_vid rises; latency is checked against a history of driven valids.
module tb_bcd2bin;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 11;
  localparam int unsigned WORD_W = 4 * DIGITS + 1;
  localparam int unsigned LAT    = DIGITS + 1;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             ovf;
    logic             err;
  } exp_t;

  logic               clk;
  logic               rstn;
  logic [WORD_W-1:0]  bcd;
  logic               bcd_vid;
  logic [BIN_W-1:0]   bin;
  logic               bin_vid;
  logic               ovf;
  logic               err;

  int unsigned n_tests;
  int unsigned n_fail;
  exp_t        sb_q[$];
  logic [LAT:0] vid_hist;

  bcd2bin #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bcd     (bcd),
    .bcd_vid (bcd_vid),
    .bin     (bin),
    .bin_vid (bin_vid),
    .ovf     (ovf),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference conversion from integer arithmetic.
  function automatic exp_t model(input logic [WORD_W-1:0] w);
    exp_t r;
    int   mag;
    int   val;
    logic bad;
    logic [3:0] d;
    r   = '0;
    mag = 0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d   = w[4*i +: 4];
      bad = bad | (d > 4'd9);
      mag = mag * 10 + int'(d);
    end
    if (bad) begin
      r.err = 1'b1;
      return r;
    end
    val = w[WORD_W-1] ? -mag : mag;
    r.ovf = (val > 1023) || (val < -1024);
`ifdef BCD2BIN_SAT_EN
    if (r.ovf) r.bin = w[WORD_W-1] ? 11'h400 : 11'h3FF;
    else       r.bin = val[BIN_W-1:0];
`else
    r.bin = val[BIN_W-1:0];
`endif
    return r;
  endfunction

  // One clock: drive, let the edge pass, then check the registered outputs.
  task automatic step(input logic vid, input logic [WORD_W-1:0] word);
    exp_t e;
    bcd     = word;
    bcd_vid = vid;
    if (vid) sb_q.push_back(model(word));
    @(posedge clk);
    vid_hist = {vid_hist[LAT-1:0], vid};
    #1;
    chk("bin_vid", 32'(bin_vid), 32'(vid_hist[LAT]));
    if (bin_vid) begin
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("bin", 32'(bin), 32'(e.bin));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("err", 32'(err), 32'(e.err));
      end
    end else begin
      chk("idle_bin", 32'(bin), 32'd0);
      chk("idle_ovf", 32'(ovf), 32'd0);
      chk("idle_err", 32'(err), 32'd0);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    w = '0;
    w[WORD_W-1] = 1'($urandom_range(0, 1));
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 15) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            w[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    vid_hist = '0;
    rstn     = 1'b0;
    bcd      = '0;
    bcd_vid  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_vid", 32'(bin_vid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single word, checks latency and basic value.
    step(1'b1, 17'h00123);
    flush(LAT + 1);

    // Back-to-back: -456, +1023, -1024, -0, then overflows both ways.
    step(1'b1, 17'h10456);
    step(1'b1, 17'h01023);
    step(1'b1, 17'h11024);
    step(1'b1, 17'h10000);
    step(1'b1, 17'h02000);
    step(1'b1, 17'h11025);
    // Illegal digit followed by a legal word.
    step(1'b1, 17'h001A3);
    step(1'b1, 17'h00045);
    // Bubble with garbage on the invalid slot.
    step(1'b1, 17'h00077);
    step(1'b0, 17'h1FFFF);
    step(1'b1, 17'h10088);
    flush(LAT + 1);

    // Reset while three words are in flight.
    step(1'b1, 17'h00111);
    step(1'b1, 17'h10222);
    step(1'b1, 17'h00333);
    bcd_vid = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("mid_rst_bin", 32'(bin), 32'd0);
    chk("mid_rst_vid", 32'(bin_vid), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    sb_q.delete();
    vid_hist = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    flush(LAT + 2);
    step(1'b1, 17'h00999);
    flush(LAT + 1);

    // Random traffic with random bubbles.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_word());
    end
    flush(LAT + 1);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
